// File: rtl/hazard_filter.sv
// hazard_filter: synchronises a glitch-prone combinational signal and only lets a level
// change through to dout once it has been seen for STABLE_CYCLES consecutive samples.
// Shorter excursions are rejected, and each rejection can be counted.
// Optional feature macro: HAZARD_FILTER_GLITCH_COUNT_EN builds the glitch counter;
// without it glitch_cnt is tied to zero and clr_cnt is ignored.
`timescale 1ns/1ps

module hazard_filter #(
    parameter int STABLE_CYCLES = 3,
    parameter int CNT_W         = 8
) (
    input  logic             CLK,
    input  logic             nRESET,
    input  logic             din,
    input  logic             clr_cnt,
    output logic             dout,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] glitch_cnt
);

    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam logic [SW-1:0] LAST_CNT  = SW'(STABLE_CYCLES - 1);
    localparam logic [SW-1:0] FIRST_CNT = SW'(1);

    if (STABLE_CYCLES < 1) begin : g_bad_stable_cycles
        $error("hazard_filter: STABLE_CYCLES must be >= 1");
    end

    typedef enum logic {
        ST_STABLE,
        ST_PENDING
    } state_t;

    state_t        state_q;
    logic [SW-1:0] stab_cnt_q;
    logic          s1_q;
    logic          s2_q;
    logic          dout_q;
    logic          rise_q;
    logic          fall_q;

    // Two-flop synchroniser; only s2_q is used downstream
    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= din;
            s2_q <= s1_q;
        end
    end

    // Debounce FSM with registered level and strobe outputs.
    // The edge that first sees s2 differ from dout counts as the first stable sample,
    // so entry loads stab_cnt with 1 (or commits at once when STABLE_CYCLES is 1);
    // this puts the commit on edge STABLE_CYCLES+2 after a clean step on din.
    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            state_q    <= ST_STABLE;
            stab_cnt_q <= '0;
            dout_q     <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            case (state_q)
                ST_STABLE: begin
                    stab_cnt_q <= '0;
                    if (s2_q != dout_q) begin
                        if (STABLE_CYCLES == 1) begin
                            dout_q <= s2_q;
                            rise_q <= s2_q;
                            fall_q <= ~s2_q;
                        end else begin
                            stab_cnt_q <= FIRST_CNT;
                            state_q    <= ST_PENDING;
                        end
                    end
                end
                ST_PENDING: begin
                    if (s2_q == dout_q) begin
                        stab_cnt_q <= '0;
                        state_q    <= ST_STABLE;
                    end else if (stab_cnt_q == LAST_CNT) begin
                        dout_q     <= s2_q;
                        rise_q     <= s2_q;
                        fall_q     <= ~s2_q;
                        stab_cnt_q <= '0;
                        state_q    <= ST_STABLE;
                    end else begin
                        stab_cnt_q <= stab_cnt_q + 1'b1;
                    end
                end
                default: begin
                    stab_cnt_q <= '0;
                    state_q    <= ST_STABLE;
                end
            endcase
        end
    end

`ifdef HAZARD_FILTER_GLITCH_COUNT_EN
    logic             reject;
    logic [CNT_W-1:0] glitch_cnt_q;
    logic [CNT_W-1:0] glitch_cnt_d;

    // Rejection: a pending change fell back to the committed level before maturing
    always_comb begin
        reject = (state_q == ST_PENDING) && (s2_q == dout_q);
    end

    // Saturating glitch count; a clear beats a simultaneous rejection
    always_comb begin
        glitch_cnt_d = glitch_cnt_q;
        if (clr_cnt) begin
            glitch_cnt_d = '0;
        end else if (reject && (glitch_cnt_q != '1)) begin
            glitch_cnt_d = glitch_cnt_q + 1'b1;
        end
    end

    // Glitch counter register
    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            glitch_cnt_q <= '0;
        end else begin
            glitch_cnt_q <= glitch_cnt_d;
        end
    end

    assign glitch_cnt = glitch_cnt_q;
`else
    logic unused_clr_cnt;
    assign unused_clr_cnt = clr_cnt;
    assign glitch_cnt     = '0;
`endif

    assign dout = dout_q;
    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: tb/tb_hazard_filter.sv
// Directed bench for hazard_filter (STABLE_CYCLES=3). A second instance with CNT_W=2
// exercises counter saturation. Glitch-count expectations follow the
// HAZARD_FILTER_GLITCH_COUNT_EN macro.
`timescale 1ns/1ps

module tb_hazard_filter;

    logic       CLK = 1'b0;
    logic       nRESET = 1'b0;
    logic       din = 1'b0;
    logic       clr_cnt = 1'b0;
    logic       dout, rise, fall;
    logic [7:0] glitch_cnt;

    logic       din2 = 1'b0;
    logic       clr2 = 1'b0;
    logic       dout2, rise2, fall2;
    logic [1:0] glitch_cnt2;

    int vectors = 0;
    int miscompares = 0;

    always #5 CLK = ~CLK;

    hazard_filter #(.STABLE_CYCLES(3), .CNT_W(8)) dut (
        .CLK(CLK), .nRESET(nRESET), .din(din), .clr_cnt(clr_cnt),
        .dout(dout), .rise(rise), .fall(fall), .glitch_cnt(glitch_cnt)
    );

    hazard_filter #(.STABLE_CYCLES(3), .CNT_W(2)) dut2 (
        .CLK(CLK), .nRESET(nRESET), .din(din2), .clr_cnt(clr2),
        .dout(dout2), .rise(rise2), .fall(fall2), .glitch_cnt(glitch_cnt2)
    );

    // One rising edge, then settle 1ns for sampling
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Pulse of 2 CLK periods on dut2 input, rejection lands on edge 5; optional clear there
    task automatic pulse2(input logic clr_at_reject);
        @(negedge CLK); din2 = 1'b1;
        tick(); tick();
        @(negedge CLK); din2 = 1'b0;
        tick(); tick();
        @(negedge CLK); clr2 = clr_at_reject;
        tick();
        @(negedge CLK); clr2 = 1'b0;
        tick(); tick(); tick();
    endtask

    task automatic test_reset();
        @(negedge CLK);
        nRESET = 1'b0; din = 1'b1;
        tick(); tick();
        vectors++; if (dout !== 1'b0) begin miscompares++; $display("FAIL reset_dout got %b want 0", dout); end
        vectors++; if (rise !== 1'b0) begin miscompares++; $display("FAIL reset_rise got %b want 0", rise); end
        vectors++; if (fall !== 1'b0) begin miscompares++; $display("FAIL reset_fall got %b want 0", fall); end
        vectors++; if (glitch_cnt !== 8'd0) begin miscompares++; $display("FAIL reset_gcnt got %0d want 0", glitch_cnt); end
        @(negedge CLK);
        din = 1'b0; nRESET = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        vectors++; if (dout !== 1'b0) begin miscompares++; $display("FAIL post_reset_dout got %b want 0", dout); end
    endtask

    task automatic test_step();
        @(negedge CLK); din = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            vectors++; if (dout !== (e >= 5)) begin miscompares++; $display("FAIL step_up_dout edge %0d got %b want %b", e, dout, (e >= 5)); end
            vectors++; if (rise !== (e == 5)) begin miscompares++; $display("FAIL step_up_rise edge %0d got %b want %b", e, rise, (e == 5)); end
            vectors++; if (fall !== 1'b0) begin miscompares++; $display("FAIL step_up_fall edge %0d got %b want 0", e, fall); end
        end
        @(negedge CLK); din = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            vectors++; if (dout !== (e < 5)) begin miscompares++; $display("FAIL step_dn_dout edge %0d got %b want %b", e, dout, (e < 5)); end
            vectors++; if (fall !== (e == 5)) begin miscompares++; $display("FAIL step_dn_fall edge %0d got %b want %b", e, fall, (e == 5)); end
            vectors++; if (rise !== 1'b0) begin miscompares++; $display("FAIL step_dn_rise edge %0d got %b want 0", e, rise); end
        end
        vectors++; if (glitch_cnt !== 8'd0) begin miscompares++; $display("FAIL step_gcnt got %0d want 0", glitch_cnt); end
    endtask

    task automatic test_short_pulse();
        logic [7:0] exp_cnt;
`ifdef HAZARD_FILTER_GLITCH_COUNT_EN
        exp_cnt = 8'd1;
`else
        exp_cnt = 8'd0;
`endif
        @(negedge CLK); din = 1'b1;
        tick(); tick();
        @(negedge CLK); din = 1'b0;
        for (int e = 3; e <= 10; e++) begin
            tick();
            vectors++; if ({dout, rise, fall} !== 3'b000) begin miscompares++; $display("FAIL short_outputs edge %0d got %b want 000", e, {dout, rise, fall}); end
        end
        vectors++; if (glitch_cnt !== exp_cnt) begin miscompares++; $display("FAIL short_gcnt got %0d want %0d", glitch_cnt, exp_cnt); end
    endtask

    // din from y = a&b | ~a&c with 5ps per gate, stepped in 5ps time slices
    task automatic test_hazard();
        logic [2:0] xx;
        logic na, t1, t2, y;
        logic na_n, t1_n, t2_n, y_n;
        logic saw_glitch;
        xx = 3'b000; na = 1'b1; t1 = 1'b0; t2 = 1'b0; y = 1'b0;
        saw_glitch = 1'b0;
        @(negedge CLK);
        for (int t = 0; t < 30; t++) begin
            if (t == 0) xx = 3'b111;
            if (t == 5) xx = 3'b000;
            na_n = ~xx[2];
            t1_n = xx[2] & xx[1];
            t2_n = na & xx[0];
            y_n  = t1 | t2;
            na = na_n; t1 = t1_n; t2 = t2_n; y = y_n;
            din = y;
            if (y) saw_glitch = 1'b1;
            #0.005;
        end
        vectors++; if (saw_glitch !== 1'b1) begin miscompares++; $display("FAIL hazard_model_active got %b want 1", saw_glitch); end
        for (int e = 1; e <= 10; e++) begin
            tick();
            vectors++; if ({rise, fall} !== 2'b00) begin miscompares++; $display("FAIL hazard_strobes edge %0d got %b want 00", e, {rise, fall}); end
        end
        // truth table for xx=000 gives y=0
        vectors++; if (dout !== 1'b0) begin miscompares++; $display("FAIL hazard_dout got %b want 0", dout); end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_cnt;
        for (int k = 1; k <= 5; k++) begin
            pulse2(1'b0);
`ifdef HAZARD_FILTER_GLITCH_COUNT_EN
            exp_cnt = (k > 3) ? 2'd3 : 2'(k);
`else
            exp_cnt = 2'd0;
`endif
            vectors++; if (glitch_cnt2 !== exp_cnt) begin miscompares++; $display("FAIL sat_gcnt pulse %0d got %0d want %0d", k, glitch_cnt2, exp_cnt); end
            vectors++; if (dout2 !== 1'b0) begin miscompares++; $display("FAIL sat_dout pulse %0d got %b want 0", k, dout2); end
        end
        pulse2(1'b1);
        vectors++; if (glitch_cnt2 !== 2'd0) begin miscompares++; $display("FAIL clr_vs_reject got %0d want 0", glitch_cnt2); end
        pulse2(1'b0);
`ifdef HAZARD_FILTER_GLITCH_COUNT_EN
        exp_cnt = 2'd1;
`else
        exp_cnt = 2'd0;
`endif
        vectors++; if (glitch_cnt2 !== exp_cnt) begin miscompares++; $display("FAIL count_after_clr got %0d want %0d", glitch_cnt2, exp_cnt); end
    endtask

    task automatic test_reset_mid_pending();
        @(negedge CLK); din = 1'b1;
        tick(); tick(); tick();
        @(negedge CLK); nRESET = 1'b0;
        for (int e = 4; e <= 6; e++) begin
            tick();
            vectors++; if ({dout, rise} !== 2'b00) begin miscompares++; $display("FAIL midrst_outputs edge %0d got %b want 00", e, {dout, rise}); end
        end
        @(negedge CLK); nRESET = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            vectors++; if (rise !== (e == 5)) begin miscompares++; $display("FAIL midrst_rise edge %0d got %b want %b", e, rise, (e == 5)); end
            vectors++; if (dout !== (e >= 5)) begin miscompares++; $display("FAIL midrst_dout edge %0d got %b want %b", e, dout, (e >= 5)); end
        end
    endtask

    initial begin
        test_reset();
        test_step();
        test_short_pulse();
        test_hazard();
        test_saturation();
        test_reset_mid_pending();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
